// File: rtl/nexys_starship_break_sched_pkg.sv
// Shared definitions for the Nexys Starship break scheduler: FSM state
// encodings, the LFSR feedback mask and the subsystem index constants.
package nexys_starship_pkg;

    // One-hot state encoding, the same style the subsystem FSMs use
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        ARMED  = 4'b0010,
        SELECT = 4'b0100,
        FIRE   = 4'b1000
    } sched_state_t;

    // Galois feedback mask (x^16 + x^14 + x^13 + x^11 + 1, maximal length)
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Panel index constants
    localparam int TL = 0;
    localparam int TR = 1;
    localparam int BL = 2;
    localparam int BR = 3;

endpackage

// File: rtl/nexys_starship_break_sched_lfsr16.sv
// Free-running 16-bit Galois LFSR. It steps every clock regardless of the
// scheduler state, so the random choices depend on when the player acts.
module nexys_starship_lfsr16
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic [15:0] state
);

    // Shift right, folding the mask in whenever a one falls out of bit 0
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= SEED;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/nexys_starship_break_sched.sv
// Central break scheduler for the Nexys Starship panels. Counts game ticks
// down to the next break, hunts for an eligible panel, then fires a one-cycle
// strobe with a nonzero repair combo. The period shrinks each level.
// Optional feature macro: SCHED_GRACE_EN (repaired panels get a 20-tick
// grace window before they may be broken again).
module nexys_starship_break_sched
    import nexys_starship_pkg::*;
#(
    parameter int          NUM_SUBSYS       = 4,
    parameter int          PERIOD_INIT      = 300,
    parameter int          PERIOD_MIN       = 60,
    parameter int          PERIOD_STEP      = 30,
    parameter int          BREAKS_PER_LEVEL = 4,
    parameter int          MAX_BROKEN       = 2,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  tick,
    input  logic                  play_flag,
    input  logic                  gameover_ctrl,
    input  logic [NUM_SUBSYS-1:0] broken,
    output logic [NUM_SUBSYS-1:0] break_strobe,
    output logic [3:0]            random_hex,
    output logic [2:0]            level,
    output logic                  sched_active
);

    localparam int IDX_W = $clog2(NUM_SUBSYS);

    sched_state_t          state;
    logic [15:0]           lfsr;
    logic                  lfsr_unused;
    logic [15:0]           period;
    logic [15:0]           period_next;
    logic [16:0]           period_sub;
    logic [15:0]           countdown;
    logic [7:0]            break_cnt;
    logic [IDX_W-1:0]      cand;
    logic [NUM_SUBSYS-1:0] cand_onehot;
    logic [NUM_SUBSYS-1:0] skip;
    logic [3:0]            broken_cnt;
    logic                  over_cap;
    logic [3:0]            hex_pick;

    nexys_starship_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .state   (lfsr)
    );

    assign lfsr_unused = ^lfsr;
    assign cand_onehot = {{(NUM_SUBSYS-1){1'b0}}, 1'b1} << cand;
    assign hex_pick    = (lfsr[3:0] == 4'h0) ? 4'h1 : lfsr[3:0];
    assign over_cap    = broken_cnt >= 4'(MAX_BROKEN);

    // Count live broken panels to enforce the simultaneous-break cap
    always_comb begin
        broken_cnt = 4'd0;
        for (int i = 0; i < NUM_SUBSYS; i++) begin
            broken_cnt = broken_cnt + {3'b000, broken[i]};
        end
    end

    // Next period after a level-up, computed one bit wider so it cannot wrap
    always_comb begin
        period_sub = {1'b0, period} - 17'(PERIOD_STEP);
        if (period_sub[16] || (period_sub < 17'(PERIOD_MIN))) begin
            period_next = 16'(PERIOD_MIN);
        end else begin
            period_next = period_sub[15:0];
        end
    end

`ifdef SCHED_GRACE_EN
    logic [NUM_SUBSYS-1:0] broken_q;
    logic [5:0]            grace [NUM_SUBSYS];
    logic [NUM_SUBSYS-1:0] grace_busy;

    // Load a grace window when a panel is repaired and drain it on game ticks
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            broken_q <= '0;
            for (int i = 0; i < NUM_SUBSYS; i++) grace[i] <= 6'd0;
        end else begin
            broken_q <= broken;
            for (int i = 0; i < NUM_SUBSYS; i++) begin
                if (gameover_ctrl) begin
                    grace[i] <= 6'd0;
                end else if (broken_q[i] && !broken[i]) begin
                    grace[i] <= 6'd20;
                end else if (tick && (grace[i] != 6'd0)) begin
                    grace[i] <= grace[i] - 6'd1;
                end
            end
        end
    end

    // A panel still in its grace window is skipped like a broken one
    always_comb begin
        for (int i = 0; i < NUM_SUBSYS; i++) grace_busy[i] = (grace[i] != 6'd0);
    end

    assign skip = broken | grace_busy;
`else
    assign skip = broken;
`endif

    // Scheduler FSM with registered outputs; game over overrides everything
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            break_strobe <= '0;
            random_hex   <= 4'h0;
            level        <= 3'd0;
            sched_active <= 1'b0;
            period       <= 16'(PERIOD_INIT);
            countdown    <= 16'(PERIOD_INIT);
            break_cnt    <= 8'd0;
            cand         <= '0;
        end else begin
            break_strobe <= '0;
            if (gameover_ctrl) begin
                state        <= IDLE;
                sched_active <= 1'b0;
                level        <= 3'd0;
                period       <= 16'(PERIOD_INIT);
                countdown    <= 16'(PERIOD_INIT);
                break_cnt    <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (play_flag) begin
                            countdown    <= period;
                            state        <= ARMED;
                            sched_active <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (tick) begin
                            countdown <= countdown - 16'd1;
                            if (countdown <= 16'd1) begin
                                cand  <= lfsr[4 +: IDX_W];
                                state <= SELECT;
                            end
                        end
                    end
                    SELECT: begin
                        if (!over_cap) begin
                            if (skip[cand]) begin
                                cand <= cand + IDX_W'(1);
                            end else begin
                                state        <= FIRE;
                                break_strobe <= cand_onehot;
                                random_hex   <= hex_pick;
                            end
                        end
                    end
                    FIRE: begin
                        state <= ARMED;
                        if ((break_cnt + 8'd1) >= 8'(BREAKS_PER_LEVEL)) begin
                            break_cnt <= 8'd0;
                            level     <= (level == 3'd7) ? 3'd7 : level + 3'd1;
                            period    <= period_next;
                            countdown <= period_next;
                        end else begin
                            break_cnt <= break_cnt + 8'd1;
                            countdown <= period;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        sched_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nexys_starship_break_sched.sv
// Self-checking bench for nexys_starship_break_sched. A behavioural model
// tracks the game from the rules (tick counts, search, level/period) and
// pushes each expected break into a scoreboard; a monitor pops and compares
// whenever a strobe is due or seen.
module tb_nexys_starship_break_sched;

    localparam int          NS     = 4;
    localparam int          P_INIT = 12;
    localparam int          P_MIN  = 4;
    localparam int          P_STEP = 3;
    localparam int          BPL    = 2;
    localparam int          MAX_B  = 2;
    localparam logic [15:0] SEED   = 16'hACE1;

    localparam int PH_IDLE = 0;
    localparam int PH_COUNT = 1;
    localparam int PH_HUNT = 2;
    localparam int PH_FIRE = 3;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          tick = 1'b0;
    logic          play_flag = 1'b0;
    logic          gameover_ctrl = 1'b0;
    logic [NS-1:0] broken = '0;
    logic [NS-1:0] break_strobe;
    logic [3:0]    random_hex;
    logic [2:0]    level;
    logic          sched_active;

    nexys_starship_break_sched #(
        .NUM_SUBSYS       (NS),
        .PERIOD_INIT      (P_INIT),
        .PERIOD_MIN       (P_MIN),
        .PERIOD_STEP      (P_STEP),
        .BREAKS_PER_LEVEL (BPL),
        .MAX_BROKEN       (MAX_B),
        .LFSR_SEED        (SEED)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .tick          (tick),
        .play_flag     (play_flag),
        .gameover_ctrl (gameover_ctrl),
        .broken        (broken),
        .break_strobe  (break_strobe),
        .random_hex    (random_hex),
        .level         (level),
        .sched_active  (sched_active)
    );

    always #5 Clk = ~Clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int strobe_seen = 0;

    typedef struct {
        int idx;
        int hex;
        int cyc;
    } ev_t;

    ev_t sb_q[$];
    ev_t ev_push;
    ev_t ev_pop;

    int          m_phase = PH_IDLE;
    int          m_left = P_INIT;
    int          m_period = P_INIT;
    int          m_breaks = 0;
    int          m_level = 0;
    int          m_cand = 0;
    int          m_cyc = 0;
    logic [15:0] m_lfsr = SEED;
    logic        m_busy;
`ifdef SCHED_GRACE_EN
    int            m_grace [NS];
    logic [NS-1:0] m_prev = '0;
`endif

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vec_cnt++;
        if (actual != expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        vec_cnt++;
        err_cnt++;
        $display("[TB] FAIL %s: wait bound expired, got timeout, want event (t=%0t)", name, $time);
    endtask

    // Drive inputs for the coming edge, then step just past it
    task automatic applyStimulus(input logic t, input logic p, input logic g, input logic [NS-1:0] b);
        tick          = t;
        play_flag     = p;
        gameover_ctrl = g;
        broken        = b;
        @(posedge Clk);
        #1;
    endtask

    // Reference model of the game rules, stepped once per clock
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_phase  = PH_IDLE;
            m_left   = P_INIT;
            m_period = P_INIT;
            m_breaks = 0;
            m_level  = 0;
            m_cand   = 0;
            m_lfsr   = SEED;
            sb_q.delete();
`ifdef SCHED_GRACE_EN
            m_prev = '0;
            for (int i = 0; i < NS; i++) m_grace[i] = 0;
`endif
        end else begin
            m_cyc++;
            if (gameover_ctrl) begin
                m_phase  = PH_IDLE;
                m_level  = 0;
                m_period = P_INIT;
                m_breaks = 0;
            end else begin
                case (m_phase)
                    PH_IDLE: if (play_flag) begin
                        m_left  = m_period;
                        m_phase = PH_COUNT;
                    end
                    PH_COUNT: if (tick) begin
                        if (m_left <= 1) begin
                            m_cand  = (int'(m_lfsr) / 16) % NS;
                            m_phase = PH_HUNT;
                        end
                        m_left = m_left - 1;
                    end
                    PH_HUNT: if ($countones(broken) < MAX_B) begin
                        m_busy = broken[m_cand];
`ifdef SCHED_GRACE_EN
                        if (m_grace[m_cand] > 0) m_busy = 1'b1;
`endif
                        if (m_busy) begin
                            m_cand = (m_cand + 1) % NS;
                        end else begin
                            m_phase     = PH_FIRE;
                            ev_push.idx = m_cand;
                            ev_push.hex = ((int'(m_lfsr) % 16) == 0) ? 1 : (int'(m_lfsr) % 16);
                            ev_push.cyc = m_cyc;
                            sb_q.push_back(ev_push);
                        end
                    end
                    default: begin
                        m_breaks++;
                        if (m_breaks == BPL) begin
                            m_breaks = 0;
                            if (m_level < 7) m_level++;
                            m_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
                        end
                        m_left  = m_period;
                        m_phase = PH_COUNT;
                    end
                endcase
            end
`ifdef SCHED_GRACE_EN
            for (int i = 0; i < NS; i++) begin
                if (gameover_ctrl) m_grace[i] = 0;
                else if (m_prev[i] && !broken[i]) m_grace[i] = 20;
                else if (tick && m_grace[i] > 0) m_grace[i] = m_grace[i] - 1;
            end
            m_prev = broken;
`endif
            m_lfsr = lfsrStep(m_lfsr);
        end
    end

    // Monitor: compare level/activity every cycle and strobes against the scoreboard
    always @(negedge Clk) begin
        if (Reset_n) begin
            checkOutput("level", int'(level), m_level);
            checkOutput("sched_active", int'(sched_active), (m_phase != PH_IDLE) ? 1 : 0);
            if (break_strobe != '0) strobe_seen++;
            if (break_strobe != '0 || (sb_q.size() != 0 && sb_q[0].cyc <= m_cyc)) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_strobe", int'(break_strobe), 0);
                end else begin
                    ev_pop = sb_q.pop_front();
                    checkOutput("strobe_vec", int'(break_strobe), 1 << ev_pop.idx);
                    checkOutput("strobe_cycle", m_cyc, ev_pop.cyc);
                    checkOutput("random_hex", int'(random_hex), ev_pop.hex);
                end
            end
        end
    end

    int          saved;
    int          bsel;
    logic [NS-1:0] brk;
    bit          done;

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("reset_strobe", int'(break_strobe), 0);
        checkOutput("reset_hex", int'(random_hex), 0);
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_active", int'(sched_active), 0);
        Reset_n = 1'b1;
        applyStimulus(0, 0, 0, '0);

        // First break with a tick every four clocks and nothing broken
        applyStimulus(0, 1, 0, '0);
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            applyStimulus((i % 4) == 3, 0, 0, '0);
            if (strobe_seen >= 1) done = 1;
        end
        if (!done) reportTimeout("first_break");
        checkOutput("first_break_count", strobe_seen, 1);

        // Two panels broken: the search must stall, then resume after a repair
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            applyStimulus(1, 0, 0, 4'b0011);
            if (m_phase == PH_HUNT) done = 1;
        end
        if (!done) reportTimeout("reach_search");
        saved = strobe_seen;
        for (int i = 0; i < 12; i++) applyStimulus(i[0], 0, 0, 4'b0011);
        checkOutput("capped_no_strobe", strobe_seen, saved);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 4'b0010);
        checkOutput("uncapped_strobe", strobe_seen, saved + 1);

        // Game over landing on the expiring tick
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            applyStimulus(1, 0, 0, '0);
            if (m_phase == PH_COUNT && m_left == 1) done = 1;
        end
        if (!done) reportTimeout("reach_expiry");
        saved = strobe_seen;
        applyStimulus(1, 0, 1, '0);
        checkOutput("gameover_active", int'(sched_active), 0);
        checkOutput("gameover_level", int'(level), 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, '0);
        checkOutput("gameover_no_strobe", strobe_seen, saved);

        // Run fast until the level saturates and the period floors
        applyStimulus(0, 1, 0, '0);
        done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            applyStimulus(1, 0, 0, '0);
            if (m_level == 7 && m_period == P_MIN && m_breaks == 1) done = 1;
        end
        if (!done) reportTimeout("level_saturate");
        for (int i = 0; i < 60; i++) applyStimulus(1, 0, 0, '0);
        checkOutput("level_saturated", int'(level), 7);

        // Randomized play, with one asynchronous reset in the middle
        brk = '0;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                bsel = $urandom_range(0, NS - 1);
                brk[bsel] = ($urandom_range(0, 2) == 0);
            end
            if (i == 7000) begin
                Reset_n = 1'b0;
                #1;
                checkOutput("midreset_strobe", int'(break_strobe), 0);
                checkOutput("midreset_level", int'(level), 0);
                checkOutput("midreset_active", int'(sched_active), 0);
                applyStimulus(0, 0, 0, brk);
                Reset_n = 1'b1;
            end
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0,
                          $urandom_range(0, 1499) == 0, brk);
        end

        applyStimulus(0, 0, 1, '0);
        applyStimulus(0, 0, 0, '0);
        checkOutput("pending_breaks", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/nexys_starship_break_sched.md
Name: nexys_starship_break_sched

Overview:
- Central break scheduler for the Nexys Starship subsystems (TL, TR, BL, BR panels).
- Decides when and which subsystem breaks, and the 4-bit repair combo it receives.
- Drives each subsystem's `*_random` strobe and shared hex bus from one LFSR.
- Shortens the inter-break period as play progresses and caps the number of simultaneously broken subsystems.

Parameters:
- NUM_SUBSYS, 4: number of subsystems; must be a power of two, 2..8.
- PERIOD_INIT, 300: game ticks between breaks at level 0.
- PERIOD_MIN, 60: floor on the period.
- PERIOD_STEP, 30: period reduction per level-up.
- BREAKS_PER_LEVEL, 4: breaks issued before each level-up.
- MAX_BROKEN, 2: maximum simultaneously broken subsystems.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle game-tick enable.
- play_flag  in  1  game start request.
- gameover_ctrl  in  1  game over; return to idle.
- broken  in  NUM_SUBSYS  live `*_broken` flags from the subsystems.
- break_strobe  out  NUM_SUBSYS  one-hot, one-cycle break command (feeds `*_random`).
- random_hex  out  4  repair combo; valid in the `break_strobe` cycle.
- level  out  3  current difficulty level, saturating at 7.
- sched_active  out  1  high in ARMED, SELECT and FIRE.

Behaviour:
- Reset values: `break_strobe`=0, `random_hex`=0, `level`=0, `sched_active`=0, period=PERIOD_INIT, countdown=PERIOD_INIT, break count=0, lfsr=LFSR_SEED, state=IDLE.
- LFSR:
  - 16-bit Galois, mask 16'hB400.
  - Advances every clock in every state, so randomness depends on player timing.
  - Never zero.
- IDLE: outputs low. On `play_flag`: load countdown=period, go to ARMED.
- ARMED:
  - On `tick`, decrement countdown.
  - When countdown==0 on a `tick`, latch cand = lfsr[4+:log2(NUM_SUBSYS)], go to SELECT.
- SELECT:
  - One candidate per cycle.
  - Stay in SELECT if popcount(`broken`) >= MAX_BROKEN.
  - Otherwise, if `broken[cand]`, set cand = cand+1 (mod NUM_SUBSYS) and stay.
  - Otherwise go to FIRE.
  - Search is bounded by NUM_SUBSYS cycles. If all are broken, hold in SELECT, re-evaluating each cycle, until one is repaired.
- FIRE (exactly one cycle):
  - `break_strobe[cand]`=1.
  - `random_hex`=lfsr[3:0], forced to 4'h1 if lfsr[3:0]==0 so the combo is never trivially 0.
  - Increment break count.
  - Set countdown=period, then go to ARMED.
- Level-up (evaluated in FIRE):
  - When break count reaches BREAKS_PER_LEVEL, clear it and increment `level` (saturating at 7).
  - period = max(period-PERIOD_STEP, PERIOD_MIN). Subtraction is done wide enough to avoid underflow.
  - The new period applies to the countdown loaded in that same FIRE cycle.
- `random_hex` holds its last value outside FIRE; subsystems sample it only with the strobe.
- `gameover_ctrl` has priority over every transition from any state. It goes to IDLE next cycle and resets level, period and break count; the LFSR keeps running. A strobe pending in that cycle is suppressed.
- `play_flag` while not IDLE: ignored.
- Simultaneous `tick` and SELECT/FIRE: the tick is ignored (no countdown in those states).
- Reset_n low mid-operation: all state returns to reset values immediately; no strobe is emitted.

Optional Feature:
- Macro: SCHED_GRACE_EN.
- Defined:
  - Per-subsystem 6-bit grace counter, loaded with 6'd20 on a falling edge of `broken[i]` (a repair).
  - Decremented on `tick`.
  - SELECT treats a subsystem with nonzero grace as broken (skip), but grace does not count toward MAX_BROKEN.
  - Counters clear on gameover and reset.
- Undefined: no grace logic; a repaired subsystem is immediately eligible.

Decomposition:
- Shared package nexys_starship_pkg holds:
  - state encodings (IDLE, ARMED, SELECT, FIRE; one-hot 4-bit, matching subsystem style);
  - LFSR mask 16'hB400;
  - subsystem index constants TL=0, TR=1, BL=2, BR=3.
- One sub-module: nexys_starship_lfsr16 (seed parameter, free-running, 16-bit state output).

Test Plan:
- Reset, `play_flag` pulse, PERIOD_INIT=5, `tick` every 4 clocks, `broken`=0 -> exactly one `break_strobe` bit high for one cycle after the 5th tick; `random_hex` != 0.
- `broken`=4'b0011, MAX_BROKEN=2, countdown expires -> no strobe. Clear `broken[0]` -> strobe issued within 4 cycles, to a bit whose `broken` is 0.
- Candidate at index 3 is broken, index 0 is free -> wrap-around picks index 0.
- 4 breaks with PERIOD_INIT=300, STEP=30 -> `level`=1, next interval 270 ticks. Run many breaks -> period floors at 60 and `level` saturates at 7.
- `gameover_ctrl` asserted in the countdown==0 tick cycle -> no strobe, IDLE next cycle, `level`=0, `sched_active`=0.
- With SCHED_GRACE_EN: repair subsystem 2 (1->0), then force countdown expiry with candidate 2 -> index 2 skipped for 20 ticks, eligible on the 21st.
